mem_access_unit: RTL and testbench

Multi-cycle load/store initiator between the MEM pipeline stage and the word-only data memory. It accepts one load or store per handshake and checks alignment and range, raising AdEL/AdES without touching memory. It turns byte and halfword stores into read-modify-write word accesses and returns sign- or zero-extended load data. It drives the data memory's address, write-data, write-enable and PC inputs.

---
 rtl/mem_pkg.sv | 60 ++++++
 rtl/lane_merge_ext.sv | 46 ++++
 rtl/mem_access_unit.sv | 121 ++++++++++++
 tb/tb_mem_access_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the load/store path.
//   - ReqOp encodings (OP_W, OP_HS, OP_HU, OP_BS, OP_BU)
//   - access-size decode and alignment helpers
//   - FSM state encoding for mem_access_unit
//   - default highest legal byte address
`timescale 1ns/1ps
package mem_pkg;

  localparam logic [31:0] ADDR_LIMIT_DEF = 32'h0000_2FFF;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_HS = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_BS = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_e;

  // Request fields held for the whole operation.
  typedef struct packed {
    logic        wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } req_t;

  // Undefined op codes fall back to a full-word access.
  function automatic size_e op_size(input logic [2:0] op);
    case (op)
      OP_HS, OP_HU: return SZ_HALF;
      OP_BS, OP_BU: return SZ_BYTE;
      default:      return SZ_WORD;
    endcase
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    return (op == OP_HS) || (op == OP_BS);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    case (op_size(op))
      SZ_WORD: return addr_lo != 2'b00;
      SZ_HALF: return addr_lo[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lane_merge_ext.sv
// lane_merge_ext: combinational little-endian lane handling.
//   word_i    : word read from memory
//   addr_lo_i : byte offset within the word
//   op_i      : access op (size + signedness)
//   st_data_i : store data (low byte/halfword used for sub-word stores)
//   merged_o  : word to write back (store data for word ops, lane-replaced word otherwise)
//   load_o    : selected lane, sign- or zero-extended (whole word for word ops)
`timescale 1ns/1ps
module lane_merge_ext
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output gets a value before the case so no path leaves it
  // unassigned; an unassigned path in combinational logic infers a latch.
  always_comb begin
    byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = word_i[{addr_lo_i[1], 4'b0000} +: 16];
    merged_o = word_i;
    load_o   = word_i;
    case (op_size(op_i))
      SZ_BYTE: begin
        merged_o[{addr_lo_i, 3'b000} +: 8] = st_data_i[7:0];
        load_o = op_signed(op_i) ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      end
      SZ_HALF: begin
        merged_o[{addr_lo_i[1], 4'b0000} +: 16] = st_data_i[15:0];
        load_o = op_signed(op_i) ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      end
      default: begin
        merged_o = st_data_i;
        load_o   = word_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store initiator towards a word-only memory.
//   Request side : ReqValid/ReqReady handshake, ReqWr, ReqOp, ReqAddr, ReqWData, ReqPC
//   Response side: RspValid one-cycle pulse, RspData, RspAdEL, RspAdES
//   Memory side  : MemA, MemWD, MemWr, MemRdEn, MemPC out; MemRD in (combinational read)
// Sub-word stores are done as read-modify-write. All outputs depend on the
// state and latched registers only, never directly on Req*.
`timescale 1ns/1ps
module mem_access_unit
  import mem_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWr,
  input  logic [2:0]  ReqOp,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [31:0] ReqPC,
  output logic        RspValid,
  output logic [31:0] RspData,
  output logic        RspAdEL,
  output logic        RspAdES,
  output logic [31:0] MemA,
  output logic [31:0] MemWD,
  output logic        MemWr,
  output logic        MemRdEn,
  output logic [31:0] MemPC,
  input  logic [31:0] MemRD
);

  state_e      state_q, state_d;
  req_t        req_q;
  logic [31:0] word_q;
  logic        adel_q, ades_q;

  logic        accept;
  logic        fault;
  logic [31:0] merged_word;
  logic [31:0] load_ext;

  assign accept = (state_q == ST_IDLE) && ReqValid;
  // The comparison is unsigned, so high addresses such as 0xFFFF_FFFC fault.
  assign fault  = is_misaligned(ReqOp, ReqAddr[1:0]) || (ReqAddr > ADDR_LIMIT);

  lane_merge_ext u_lane (
    .word_i    (word_q),
    .addr_lo_i (req_q.addr[1:0]),
    .op_i      (req_q.op),
    .st_data_i (req_q.wdata),
    .merged_o  (merged_word),
    .load_o    (load_ext)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      word_q  <= '0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q  <= '{wr: ReqWr, op: ReqOp, addr: ReqAddr, wdata: ReqWData, pc: ReqPC};
        adel_q <= fault && !ReqWr;
        ades_q <= fault && ReqWr;
      end
      if (state_q == ST_RD) word_q <= MemRD;
    end
  end

  always_comb begin
    state_d  = state_q;
    ReqReady = 1'b0;
    RspValid = 1'b0;
    RspData  = '0;
    RspAdEL  = 1'b0;
    RspAdES  = 1'b0;
    MemA     = '0;
    MemWD    = '0;
    MemWr    = 1'b0;
    MemRdEn  = 1'b0;
    MemPC    = req_q.pc;
    case (state_q)
      ST_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          if (fault)                                     state_d = ST_RSP;
          else if (ReqWr && op_size(ReqOp) == SZ_WORD)   state_d = ST_WR;
          else                                           state_d = ST_RD;
        end
      end
      ST_RD: begin
        MemRdEn = 1'b1;
        MemA    = {req_q.addr[31:2], 2'b00};
        // Only sub-word stores read before writing.
        state_d = req_q.wr ? ST_WR : ST_RSP;
      end
      ST_WR: begin
        MemWr   = 1'b1;
        MemA    = {req_q.addr[31:2], 2'b00};
        MemWD   = merged_word;
        state_d = ST_RSP;
      end
      ST_RSP: begin
        RspValid = 1'b1;
        RspAdEL  = adel_q;
        RspAdES  = ades_q;
        if (!req_q.wr && !adel_q) RspData = load_ext;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqWr = 1'b0;
  logic [2:0]  ReqOp = '0;
  logic [31:0] ReqAddr = '0;
  logic [31:0] ReqWData = '0;
  logic [31:0] ReqPC = '0;
  logic        RspValid;
  logic [31:0] RspData;
  logic        RspAdEL;
  logic        RspAdES;
  logic [31:0] MemA;
  logic [31:0] MemWD;
  logic        MemWr;
  logic        MemRdEn;
  logic [31:0] MemPC;
  logic [31:0] MemRD;

  always #5 Clk = ~Clk;

  mem_access_unit dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .ReqWr    (ReqWr),
    .ReqOp    (ReqOp),
    .ReqAddr  (ReqAddr),
    .ReqWData (ReqWData),
    .ReqPC    (ReqPC),
    .RspValid (RspValid),
    .RspData  (RspData),
    .RspAdEL  (RspAdEL),
    .RspAdES  (RspAdES),
    .MemA     (MemA),
    .MemWD    (MemWD),
    .MemWr    (MemWr),
    .MemRdEn  (MemRdEn),
    .MemPC    (MemPC),
    .MemRD    (MemRD)
  );

  // Word memory model: combinational read, write at posedge, plus a preload port.
  logic [31:0] mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_idx = '0;
  logic [31:0] pl_data = '0;

  assign MemRD = mem[MemA[13:2]];

  always @(posedge Clk) begin
    if (MemWr)      mem[MemA[13:2]] <= MemWD;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  typedef struct {
    logic [31:0] data;
    logic        adel;
    logic        ades;
    int          lat;
    int          acc;
  } rsp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] pc;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int last_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  // Monitor: compare responses and memory writes against the scoreboard queues.
  initial forever begin
    rsp_t r;
    wr_t  w;
    @(negedge Clk);
    if (Reset) begin
      if (MemRdEn) rd_cnt++;
      if (RspValid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 32'(RspValid), 32'd0);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_data", RspData, r.data);
          check("rsp_adel", 32'(RspAdEL), 32'(r.adel));
          check("rsp_ades", 32'(RspAdES), 32'(r.ades));
          // posedge number at which RspValid is sampled high, relative to acceptance
          check("rsp_latency", 32'(cyc + 1 - r.acc), 32'(r.lat));
        end
      end
      if (MemWr) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 32'(MemWr), 32'd0);
        end else begin
          w = wr_q.pop_front();
          check("mem_addr", MemA, w.a);
          check("mem_wd", MemWD, w.wd);
          check("mem_pc", MemPC, w.pc);
        end
      end
    end
  end

  task automatic poke(input logic [11:0] idx, input logic [31:0] data);
    pl_idx  = idx;
    pl_data = data;
    pl_en   = 1'b1;
    @(posedge Clk);
    #1 pl_en = 1'b0;
    @(negedge Clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic issue(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc,
                       input logic [31:0] exp_data, input logic exp_adel, input logic exp_ades,
                       input int exp_lat, input logic exp_write, input logic [31:0] exp_wd,
                       input logic exp_rsp);
    int   waited;
    rsp_t r;
    wr_t  w;
    waited   = 0;
    ReqWr    = wr;
    ReqOp    = op;
    ReqAddr  = addr;
    ReqWData = wdata;
    ReqPC    = pc;
    ReqValid = 1'b1;
    while (!ReqReady && waited < 20) begin
      @(negedge Clk);
      waited++;
    end
    if (!ReqReady) begin
      check("accept_timeout", 32'(ReqReady), 32'd1);
      ReqValid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    if (exp_rsp) begin
      r.data = exp_data; r.adel = exp_adel; r.ades = exp_ades; r.lat = exp_lat; r.acc = cyc + 1;
      rsp_q.push_back(r);
    end
    if (exp_write) begin
      w.a = {addr[31:2], 2'b00}; w.wd = exp_wd; w.pc = pc;
      wr_q.push_back(w);
    end
    @(posedge Clk);
    #1 ReqValid = 1'b0;
    @(negedge Clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0 || !ReqReady) && n < 20) begin
      @(negedge Clk);
      n++;
    end
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_snap;
    int acc1;
    int acc2;

    repeat (2) @(negedge Clk);
    check("rst_req_ready", 32'(ReqReady), 32'd1);
    check("rst_rsp_valid", 32'(RspValid), 32'd0);
    check("rst_rsp_data", RspData, 32'd0);
    check("rst_rsp_adel", 32'(RspAdEL), 32'd0);
    check("rst_rsp_ades", 32'(RspAdES), 32'd0);
    check("rst_mem_a", MemA, 32'd0);
    check("rst_mem_wd", MemWD, 32'd0);
    check("rst_mem_pc", MemPC, 32'd0);
    check("rst_mem_wr", 32'(MemWr), 32'd0);
    check("rst_mem_rden", 32'(MemRdEn), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);

    poke(12'd4,     32'h1234_5678);  // 0x0010
    poke(12'd8,     32'h1111_2222);  // 0x0020
    poke(12'd12,    32'hAABB_CCDD);  // 0x0030
    poke(12'd16,    32'h5566_7788);  // 0x0040
    poke(12'h0BFF,  32'h7F00_0000);  // 0x2FFC

    // Word load.
    issue(1'b0, OP_W, 32'h0000_0010, 32'h0, 32'h100, 32'h1234_5678, 1'b0, 1'b0, 2, 1'b0, 32'h0, 1'b1);
    drain();

    // Sub-word loads from 0x80FF_0000: b0=00 b1=00 b2=FF b3=80.
    poke(12'd4, 32'h80FF_0000);
    issue(1'b0, OP_BS,  32'h0000_0013, 32'h0, 32'h104, 32'hFFFF_FF80, 1'b0, 1'b0, 2, 1'b0, 32'h0, 1'b1);
    issue(1'b0, OP_BU,  32'h0000_0013, 32'h0, 32'h108, 32'h0000_0080, 1'b0, 1'b0, 2, 1'b0, 32'h0, 1'b1);
    issue(1'b0, OP_BS,  32'h0000_0012, 32'h0, 32'h10C, 32'hFFFF_FFFF, 1'b0, 1'b0, 2, 1'b0, 32'h0, 1'b1);
    issue(1'b0, OP_HS,  32'h0000_0012, 32'h0, 32'h110, 32'hFFFF_80FF, 1'b0, 1'b0, 2, 1'b0, 32'h0, 1'b1);
    issue(1'b0, OP_HU,  32'h0000_0012, 32'h0, 32'h114, 32'h0000_80FF, 1'b0, 1'b0, 2, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 3'b111, 32'h0000_0010, 32'h0, 32'h118, 32'h80FF_0000, 1'b0, 1'b0, 2, 1'b0, 32'h0, 1'b1);
    drain();

    // Sub-word stores (read-modify-write).
    issue(1'b1, OP_HU, 32'h0000_0022, 32'hDEAD_BEEF, 32'h200, 32'h0, 1'b0, 1'b0, 3, 1'b1, 32'hBEEF_2222, 1'b1);
    issue(1'b1, OP_BS, 32'h0000_0031, 32'h1234_565A, 32'h204, 32'h0, 1'b0, 1'b0, 3, 1'b1, 32'hAABB_5ADD, 1'b1);
    drain();
    check("mem_0x20", mem[8], 32'hBEEF_2222);
    check("mem_0x30", mem[12], 32'hAABB_5ADD);

    // Address exceptions: no memory cycle at all.
    rd_snap = rd_cnt;
    issue(1'b0, OP_W,  32'h0000_0006, 32'h0, 32'h300, 32'h0, 1'b1, 1'b0, 1, 1'b0, 32'h0, 1'b1);
    issue(1'b1, OP_BU, 32'h0000_3000, 32'h0000_00AA, 32'h304, 32'h0, 1'b0, 1'b1, 1, 1'b0, 32'h0, 1'b1);
    issue(1'b0, OP_HS, 32'h0000_0013, 32'h0, 32'h308, 32'h0, 1'b1, 1'b0, 1, 1'b0, 32'h0, 1'b1);
    issue(1'b0, OP_W,  32'hFFFF_FFFC, 32'h0, 32'h30C, 32'h0, 1'b1, 1'b0, 1, 1'b0, 32'h0, 1'b1);
    issue(1'b1, OP_W,  32'h0000_0002, 32'h0, 32'h310, 32'h0, 1'b0, 1'b1, 1, 1'b0, 32'h0, 1'b1);
    drain();
    check("exc_no_reads", 32'(rd_cnt - rd_snap), 32'd0);

    // Top-of-range legal accesses on word 0x7F00_0000.
    issue(1'b0, OP_BS, 32'h0000_2FFF, 32'h0, 32'h400, 32'h0000_007F, 1'b0, 1'b0, 2, 1'b0, 32'h0, 1'b1);
    issue(1'b0, OP_HU, 32'h0000_2FFE, 32'h0, 32'h404, 32'h0000_7F00, 1'b0, 1'b0, 2, 1'b0, 32'h0, 1'b1);
    issue(1'b0, OP_W,  32'h0000_2FFC, 32'h0, 32'h408, 32'h7F00_0000, 1'b0, 1'b0, 2, 1'b0, 32'h0, 1'b1);
    drain();

    // Reset during the WR cycle of a byte store: no write, no response.
    issue(1'b1, OP_BU, 32'h0000_0042, 32'h0000_0099, 32'h500, 32'h0, 1'b0, 1'b0, 3, 1'b0, 32'h0, 1'b0);
    @(posedge Clk);
    #2;
    check("wr_cycle_reached", 32'(MemWr), 32'd1);
    Reset = 1'b0;
    #1;
    check("rst_mid_mem_wr", 32'(MemWr), 32'd0);
    check("rst_mid_mem_a", MemA, 32'd0);
    check("rst_mid_ready", 32'(ReqReady), 32'd1);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_ready_after", 32'(ReqReady), 32'd1);
    check("rst_mem_unchanged", mem[16], 32'h5566_7788);

    // Back-to-back word stores: accept N, WR, RSP, next accept at N+3.
    issue(1'b1, OP_W, 32'h0000_0000, 32'hCAFE_F00D, 32'h600, 32'h0, 1'b0, 1'b0, 2, 1'b1, 32'hCAFE_F00D, 1'b1);
    acc1 = last_acc;
    issue(1'b1, OP_W, 32'h0000_0004, 32'h0BAD_C0DE, 32'h604, 32'h0, 1'b0, 1'b0, 2, 1'b1, 32'h0BAD_C0DE, 1'b1);
    acc2 = last_acc;
    check("b2b_accept_gap", 32'(acc2 - acc1), 32'd3);
    drain();
    check("mem_0x00", mem[0], 32'hCAFE_F00D);
    check("mem_0x04", mem[1], 32'h0BAD_C0DE);

    check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    check("wr_queue_empty", 32'(wr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
